// File: rtl/alu_reg_sequencer.sv
// rtl/alu_reg_sequencer.sv - command FIFO and READ/WRITE sequencer for the register-file/ALU datapath
module alu_reg_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter bit SUPPRESS_OF_WB = 1'b0
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [4:0]                    cmd_rs,
  input  logic [4:0]                    cmd_rt,
  input  logic [4:0]                    cmd_rd,
  input  logic                          cmd_wb,
  output logic [4:0]                    R_Addr_A,
  output logic [4:0]                    R_Addr_B,
  output logic [4:0]                    W_Addr,
  output logic                          Write_Reg,
  output logic [2:0]                    ALU_OP,
  input  logic                          OF,
  input  logic                          ZF,
  output logic                          busy,
  output logic                          done,
  output logic                          done_of,
  output logic                          done_zf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       wb;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t        state_q, state_d;
  cmd_t          mem_q [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, full, empty;
  logic [4:0]    ra_q, rb_q, wa_q;
  logic [2:0]    op_q;
  logic          wb_q, of_q, zf_q;
  logic          write_q, done_q, done_of_q, done_zf_q;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  if (!empty) begin pop = 1'b1; state_d = READ; end
      READ:  state_d = WRITE;
      WRITE: begin
        if (!empty) begin pop = 1'b1; state_d = READ; end
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, rs: cmd_rs, rt: cmd_rt, rd: cmd_rd, wb: cmd_wb};
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      wa_q      <= '0;
      op_q      <= '0;
      wb_q      <= 1'b0;
      of_q      <= 1'b0;
      zf_q      <= 1'b0;
      write_q   <= 1'b0;
      done_q    <= 1'b0;
      done_of_q <= 1'b0;
      done_zf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        ra_q     <= head.rs;
        rb_q     <= head.rt;
        wa_q     <= head.rd;
        op_q     <= head.op;
        wb_q     <= head.wb;
      end
      if (state_q == READ) begin
        of_q <= OF;
        zf_q <= ZF;
      end
      // The live OF is used here because it is the value being captured on this same edge.
      write_q <= (state_q == READ) && wb_q && !(SUPPRESS_OF_WB && OF);
      done_q  <= (state_q == WRITE);
      if (state_q == WRITE) begin
        done_of_q <= of_q;
        done_zf_q <= zf_q;
      end
    end
  end

  assign cmd_ready  = !full;
  assign R_Addr_A   = ra_q;
  assign R_Addr_B   = rb_q;
  assign W_Addr     = wa_q;
  assign ALU_OP     = op_q;
  assign Write_Reg  = write_q;
  assign done       = done_q;
  assign done_of    = done_of_q;
  assign done_zf    = done_zf_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// tb/tb_alu_reg_sequencer.sv - scoreboard bench for alu_reg_sequencer
module tb_alu_reg_sequencer;
  logic       clk = 1'b0;
  logic       Reset, cmd_valid, cmd_ready, cmd_wb;
  logic [2:0] cmd_op, ALU_OP;
  logic [4:0] cmd_rs, cmd_rt, cmd_rd, R_Addr_A, R_Addr_B, W_Addr;
  logic       Write_Reg, OF, ZF, busy, done, done_of, done_zf;
  logic [2:0] fifo_count;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       wb;
    logic       of;
    logic       zf;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         done_times[$];
  logic [4:0] wr_log[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       prev_wr = 1'b0, prev_done = 1'b0;
  logic [4:0] prev_a = '0, prev_b = '0, prev_w = '0;
  logic [2:0] prev_op = '0;

  alu_reg_sequencer #(.FIFO_DEPTH(4), .SUPPRESS_OF_WB(1'b1)) dut (
    .clk(clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_wb(cmd_wb),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .Write_Reg(Write_Reg),
    .ALU_OP(ALU_OP), .OF(OF), .ZF(ZF),
    .busy(busy), .done(done), .done_of(done_of), .done_zf(done_zf),
    .fifo_count(fifo_count)
  );

  // Datapath stand-in: overflow when source A >= 16, zero when both sources match.
  assign OF = R_Addr_A[4];
  assign ZF = (R_Addr_A == R_Addr_B);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic wb);
    exp_t e;
    e.op = op; e.rs = rs; e.rt = rt; e.rd = rd;
    e.of = rs[4];
    e.zf = (rs == rt);
    e.wb = wb && !rs[4];
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic wb);
    logic acc;
    int   guard;
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_wb = wb;
    cmd_valid = 1'b1;
    guard = 0;
    do begin
      acc = cmd_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 50);
    cmd_valid = 1'b0;
    chk("push_accepted", acc, 1);
    if (acc) sb.push_back(make_exp(op, rs, rt, rd, wb));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 200) begin step(1); guard++; end
    chk("drain_complete", (sb.size() == 0) && !busy, 1);
  endtask

  always @(negedge clk) begin
    if (Reset) begin
      prev_wr = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (Write_Reg) begin
        chk("write_reg_single_cycle", prev_wr, 0);
        wr_log.push_back(W_Addr);
      end
      if (done) begin
        done_times.push_back(cyc);
        chk("done_single_cycle", prev_done, 0);
        chk("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("op_r_addr_a", prev_a, mon_e.rs);
          chk("op_r_addr_b", prev_b, mon_e.rt);
          chk("op_alu_op", prev_op, mon_e.op);
          chk("op_w_addr", prev_w, mon_e.rd);
          chk("op_write_reg", prev_wr, mon_e.wb);
          chk("op_done_of", done_of, mon_e.of);
          chk("op_done_zf", done_zf, mon_e.zf);
        end
      end
      prev_wr = Write_Reg; prev_done = done;
      prev_a = R_Addr_A; prev_b = R_Addr_B; prev_w = W_Addr; prev_op = ALU_OP;
    end
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    Reset = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_wb = 1'b0;
    step(2);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_outputs", {R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Write_Reg, busy, done, done_of, done_zf}, 0);
    Reset = 1'b0;
    step(1);

    push(3'd0, 5'd0, 5'd1, 5'd3, 1'b1);
    chk("lat_count_pushed", fifo_count, 1);
    chk("lat_busy", busy, 1);
    step(1);
    chk("lat_read_a", R_Addr_A, 0);
    chk("lat_read_b", R_Addr_B, 1);
    chk("lat_read_op", ALU_OP, 0);
    chk("lat_read_nowrite", Write_Reg, 0);
    chk("lat_count_popped", fifo_count, 0);
    step(1);
    chk("lat_write_en", Write_Reg, 1);
    chk("lat_write_addr", W_Addr, 3);
    step(1);
    chk("lat_write_drop", Write_Reg, 0);
    chk("lat_done", done, 1);
    chk("lat_done_zf", done_zf, 0);
    step(1);
    chk("lat_done_pulse", done, 0);
    chk("lat_idle", busy, 0);

    done_times.delete(); wr_log.delete();
    push(3'd1, 5'd2,  5'd2,  5'd4,  1'b1);
    push(3'd2, 5'd17, 5'd3,  5'd5,  1'b1);
    push(3'd3, 5'd6,  5'd7,  5'd8,  1'b0);
    push(3'd4, 5'd9,  5'd9,  5'd10, 1'b1);
    push(3'd5, 5'd20, 5'd20, 5'd11, 1'b0);
    push(3'd6, 5'd12, 5'd13, 5'd14, 1'b1);
    push(3'd7, 5'd15, 5'd1,  5'd16, 1'b1);
    chk("full_count", fifo_count, 4);
    chk("full_not_ready", cmd_ready, 0);
    cmd_op = 3'd0; cmd_rs = 5'd18; cmd_rt = 5'd19; cmd_rd = 5'd21; cmd_wb = 1'b1;
    cmd_valid = 1'b1;
    step(1);
    chk("full_pop_no_push_count", fifo_count, 3);
    chk("full_ready_rises", cmd_ready, 1);
    step(1);
    chk("full_late_push_count", fifo_count, 4);
    cmd_valid = 1'b0;
    sb.push_back(make_exp(3'd0, 5'd18, 5'd19, 5'd21, 1'b1));
    drain();
    chk("burst_done_count", done_times.size(), 8);
    for (int i = 1; i < done_times.size(); i++)
      chk("burst_done_spacing", done_times[i] - done_times[i-1], 2);
    chk("burst_write_count", wr_log.size(), 4);

    wr_log.delete();
    push(3'd0, 5'd7, 5'd2, 5'd3, 1'b1);
    push(3'd1, 5'd3, 5'd4, 5'd1, 1'b1);
    drain();
    chk("raw_write_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("raw_first_waddr", wr_log[0], 3);
      chk("raw_second_waddr", wr_log[1], 1);
    end

    done_times.delete(); wr_log.delete();
    push(3'd2, 5'd5, 5'd6, 5'd7, 1'b0);
    drain();
    chk("nowb_no_write", wr_log.size(), 0);
    chk("nowb_done", done_times.size(), 1);
    push(3'd3, 5'd16, 5'd1, 5'd9, 1'b1);
    drain();
    chk("suppress_no_write", wr_log.size(), 0);
    chk("suppress_done", done_times.size(), 2);
    chk("suppress_done_of_held", done_of, 1);

    push(3'd1, 5'd1, 5'd2,  5'd3,  1'b1);
    push(3'd2, 5'd4, 5'd5,  5'd6,  1'b1);
    push(3'd3, 5'd7, 5'd8,  5'd9,  1'b1);
    chk("pp_count_before", fifo_count, 2);
    push(3'd4, 5'd10, 5'd11, 5'd12, 1'b1);
    chk("pp_count_after", fifo_count, 2);
    chk("pp_head_rs", R_Addr_A, 4);
    chk("pp_head_op", ALU_OP, 2);
    drain();

    push(3'd5, 5'd1, 5'd3, 5'd2, 1'b1);
    push(3'd6, 5'd2, 5'd4, 5'd5, 1'b1);
    push(3'd7, 5'd6, 5'd8, 5'd9, 1'b1);
    for (int g = 0; g < 20 && !Write_Reg; g++) step(1);
    chk("rstw_in_write", Write_Reg, 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("rstw_write_drop", Write_Reg, 0);
    chk("rstw_fifo_empty", fifo_count, 0);
    chk("rstw_not_busy", busy, 0);
    chk("rstw_ready", cmd_ready, 1);
    sb.delete(); done_times.delete();
    step(1);
    chk("rstw_no_done_in_reset", done, 0);
    Reset = 1'b0;
    step(6);
    chk("rstw_no_done_after", done_times.size(), 0);
    chk("rstw_count_after", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
